// File: rtl/multi_voice_osc.sv
`default_nettype none
// ============================================================================
//  multi_voice_osc
//  N-voice time-multiplexed DDS oscillator (saw/square/triangle/noise) with
//  per-voice gain and a saturating mixer feeding an offset-binary sample port.
//  Optional macro: MULTI_VOICE_OSC_GAIN_RAMP_EN (click-free gain ramping).
//  Revision: 1.0
// ============================================================================
module multi_voice_osc #(
    parameter int C_FCK     = 48_000_000,
    parameter int C_FS      = 48_000,
    parameter int C_VOICES  = 4,
    parameter int C_PHASE_W = 24,
    parameter int C_OUT_W   = 12,
    parameter int C_GAIN_W  = 8,
    localparam int C_VW     = (C_VOICES > 1) ? $clog2(C_VOICES) : 1
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    input  logic                 EN_CK_i,
    input  logic                 WR_i,
    input  logic [C_VW-1:0]      VOICE_i,
    input  logic [1:0]           REG_i,
    input  logic [C_PHASE_W-1:0] WDAT_i,
    output logic [C_OUT_W-1:0]   DAT_o,
    output logic                 SMPL_STB_o,
    output logic                 BUSY_o
);

    localparam int C_DIV    = C_FCK / C_FS;
    localparam int C_DIV_W  = $clog2(C_DIV);
    localparam int C_ACC_W  = C_OUT_W + $clog2(C_VOICES);
    localparam int C_PROD_W = C_OUT_W + C_GAIN_W + 1;
    localparam logic [C_OUT_W-1:0] C_QUARTER = C_OUT_W'(2 ** (C_OUT_W - 2));
    localparam logic [C_OUT_W-1:0] C_MSB     = C_OUT_W'(2 ** (C_OUT_W - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_MIX  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [C_VW-1:0]    v_q, v_d;
    logic [C_DIV_W-1:0] div_q;
    logic               tick;
    logic               scan;
    logic               last_voice;

    logic [C_PHASE_W-1:0] freq_q  [C_VOICES];
    logic [1:0]           mode_q  [C_VOICES];
    logic [C_GAIN_W-1:0]  gain_q  [C_VOICES];
    logic [C_PHASE_W-1:0] phase_q [C_VOICES];
    logic [C_VOICES-1:0]  en_q;
    logic [15:0]          lfsr_q;

    logic                        voice_ok;
    logic                        wr_en;
    logic [C_OUT_W-1:0]          p_w;
    logic [C_OUT_W-1:0]          tri_sh;
    logic [C_OUT_W-2:0]          tri_u;
    logic signed [C_OUT_W-1:0]   wave_s;
    logic [C_GAIN_W-1:0]         gain_eff;
    logic                        active;
    logic signed [C_PROD_W-1:0]  prod;
    logic signed [C_ACC_W-1:0]   contrib;
    logic signed [C_ACC_W-1:0]   acc_q;
    logic [C_OUT_W-1:0]          sat;
    logic [C_OUT_W-1:0]          dat_q;
    logic                        stb_q;

    // ------------------------------------------------------------------
    // Sample-rate divider and sequencing FSM
    // ------------------------------------------------------------------
    assign tick       = (div_q == C_DIV_W'(C_DIV - 1));
    assign scan       = (state_q == S_SCAN);
    assign last_voice = (v_q == C_VW'(C_VOICES - 1));

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            div_q <= '0;
        end else if (EN_CK_i) begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    v_d     = '0;
                end
            end
            S_SCAN: begin
                if (last_voice) begin
                    state_d = S_MIX;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            S_MIX:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q <= S_IDLE;
            v_q     <= '0;
        end else if (EN_CK_i) begin
            state_q <= state_d;
            v_q     <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Register write port
    // ------------------------------------------------------------------
    generate
        if ((1 << C_VW) == C_VOICES) begin : g_vfull
            assign voice_ok = 1'b1;
        end else begin : g_vpart
            assign voice_ok = (int'(VOICE_i) < C_VOICES);
        end
    endgenerate

    assign wr_en = EN_CK_i && WR_i && voice_ok;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int i = 0; i < C_VOICES; i++) begin
                freq_q[i] <= '0;
                mode_q[i] <= '0;
                gain_q[i] <= '0;
            end
            en_q <= '0;
        end else if (wr_en) begin
            case (REG_i)
                2'd0:    freq_q[VOICE_i] <= WDAT_i;
                2'd1:    mode_q[VOICE_i] <= WDAT_i[1:0];
                2'd2:    gain_q[VOICE_i] <= WDAT_i[C_GAIN_W-1:0];
                default: en_q[VOICE_i]   <= WDAT_i[0];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-slot waveform generation
    // ------------------------------------------------------------------
    assign p_w    = phase_q[v_q][C_PHASE_W-1 -: C_OUT_W];
    // Quarter-cycle shift places the triangle zero crossing at phase 0.
    assign tri_sh = p_w + C_QUARTER;
    assign tri_u  = tri_sh[C_OUT_W-1] ? ~tri_sh[C_OUT_W-2:0] : tri_sh[C_OUT_W-2:0];

    always_comb begin
        wave_s = '0;
        case (mode_q[v_q])
            2'd0:    wave_s = p_w ^ C_MSB;
            2'd1:    wave_s = p_w[C_OUT_W-1] ? C_MSB : ~C_MSB;
            2'd2:    wave_s = {tri_u, tri_sh[C_OUT_W-1]} ^ C_MSB;
            default: wave_s = C_OUT_W'(lfsr_q);
        endcase
    end

`ifdef MULTI_VOICE_OSC_GAIN_RAMP_EN
    logic [C_GAIN_W-1:0] geff_q [C_VOICES];
    logic [C_GAIN_W-1:0] gain_tgt;

    assign gain_tgt = en_q[v_q] ? gain_q[v_q] : '0;
    assign gain_eff = geff_q[v_q];
    // A disabled voice keeps running until its gain has ramped down to zero.
    assign active   = en_q[v_q] || (geff_q[v_q] != '0);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int i = 0; i < C_VOICES; i++) begin
                geff_q[i] <= '0;
            end
        end else if (EN_CK_i && scan) begin
            if (geff_q[v_q] < gain_tgt) begin
                geff_q[v_q] <= geff_q[v_q] + 1'b1;
            end else if (geff_q[v_q] > gain_tgt) begin
                geff_q[v_q] <= geff_q[v_q] - 1'b1;
            end
        end
    end
`else
    assign gain_eff = gain_q[v_q];
    assign active   = en_q[v_q];
`endif

    assign prod    = C_PROD_W'(wave_s) * C_PROD_W'($signed({1'b0, gain_eff}));
    assign contrib = C_ACC_W'(prod >>> C_GAIN_W);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int i = 0; i < C_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else if (EN_CK_i && scan) begin
            phase_q[v_q] <= active ? phase_q[v_q] + freq_q[v_q] : '0;
        end
    end

    // Galois LFSR, taps 16,14,13,11; advances once per active noise slot.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            lfsr_q <= 16'hACE1;
        end else if (EN_CK_i && scan && active && (mode_q[v_q] == 2'd3)) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // ------------------------------------------------------------------
    // Mixer, saturation and output
    // ------------------------------------------------------------------
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            acc_q <= '0;
        end else if (EN_CK_i) begin
            if ((state_q == S_IDLE) && tick) begin
                acc_q <= '0;
            end else if (scan && active) begin
                acc_q <= acc_q + contrib;
            end
        end
    end

    generate
        if (C_ACC_W > C_OUT_W) begin : g_sat
            localparam logic signed [C_ACC_W-1:0] C_SAT_HI = C_ACC_W'(2 ** (C_OUT_W - 1) - 1);
            localparam logic signed [C_ACC_W-1:0] C_SAT_LO = C_ACC_W'(-(2 ** (C_OUT_W - 1)));
            always_comb begin
                sat = acc_q[C_OUT_W-1:0];
                if (acc_q > C_SAT_HI) begin
                    sat = C_SAT_HI[C_OUT_W-1:0];
                end else if (acc_q < C_SAT_LO) begin
                    sat = C_SAT_LO[C_OUT_W-1:0];
                end
            end
        end else begin : g_nosat
            assign sat = acc_q;
        end
    endgenerate

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            dat_q <= C_MSB;
            stb_q <= 1'b0;
        end else if (EN_CK_i) begin
            stb_q <= (state_q == S_MIX);
            if (state_q == S_MIX) begin
                dat_q <= sat ^ C_MSB;
            end
        end
    end

    assign DAT_o      = dat_q;
    assign SMPL_STB_o = stb_q;
    assign BUSY_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multi_voice_osc.sv
`default_nettype none
// ============================================================================
//  tb_multi_voice_osc
//  Self-checking bench for multi_voice_osc against a sample-level reference.
//  Revision: 1.0
// ============================================================================
module tb_multi_voice_osc;

    localparam int C_VOICES = 4;

    logic        clk = 1'b0;
    logic        xarst;
    logic        en_ck;
    logic        wr;
    logic [1:0]  voice;
    logic [1:0]  regsel;
    logic [23:0] wdat;
    logic [11:0] dat;
    logic        stb;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, advanced once per emitted sample
    int m_freq  [C_VOICES];
    int m_mode  [C_VOICES];
    int m_gain  [C_VOICES];
    int m_en    [C_VOICES];
    int m_phase [C_VOICES];
    int m_lfsr;

    multi_voice_osc #(
        .C_FCK     (48_000_000),
        .C_FS      (48_000),
        .C_VOICES  (C_VOICES),
        .C_PHASE_W (24),
        .C_OUT_W   (12),
        .C_GAIN_W  (8)
    ) dut (
        .CK_i       (clk),
        .XARST_i    (xarst),
        .EN_CK_i    (en_ck),
        .WR_i       (wr),
        .VOICE_i    (voice),
        .REG_i      (regsel),
        .WDAT_i     (wdat),
        .DAT_o      (dat),
        .SMPL_STB_o (stb),
        .BUSY_o     (busy)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < C_VOICES; v++) begin
            m_freq[v] = 0; m_mode[v] = 0; m_gain[v] = 0; m_en[v] = 0; m_phase[v] = 0;
        end
        m_lfsr = 'hACE1;
    endtask

    task automatic model_write(input int v, input int r, input int d);
        case (r)
            0:       m_freq[v] = d & 'hFFFFFF;
            1:       m_mode[v] = d & 3;
            2:       m_gain[v] = d & 255;
            default: m_en[v]   = d & 1;
        endcase
    endtask

    task automatic model_step(output int expd);
        int sum;
        sum = 0;
        for (int v = 0; v < C_VOICES; v++) begin
            int p, w, q;
            if (m_en[v] != 0) begin
                p = m_phase[v] / 4096;
                case (m_mode[v])
                    0: w = p - 2048;
                    1: w = (p < 2048) ? 2047 : -2048;
                    2: begin
                        q = (p + 1024) % 4096;
                        w = (q < 2048) ? (2 * q - 2048) : (6143 - 2 * q);
                    end
                    default: begin
                        w = m_lfsr % 4096;
                        if (w >= 2048) w = w - 4096;
                        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
                    end
                endcase
                sum = sum + floor_div(w * m_gain[v], 256);
                m_phase[v] = (m_phase[v] + m_freq[v]) % 16777216;
            end else begin
                m_phase[v] = 0;
            end
        end
        if (sum > 2047) sum = 2047;
        if (sum < -2048) sum = -2048;
        expd = sum + 2048;
    endtask

    task automatic write_reg(input int v, input int r, input int d);
        @(negedge clk);
        wr = 1'b1; voice = 2'(v); regsel = 2'(r); wdat = 24'(d);
        @(negedge clk);
        wr = 1'b0;
        model_write(v, r, d);
    endtask

    task automatic wait_stb(input int limit, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (stb === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            tests_run++; tests_failed++;
            $display("FAIL stb_timeout: no SMPL_STB_o within %0d cycles", limit);
        end
    endtask

    task automatic next_sample(output bit ok, output int expd);
        expd = 0;
        wait_stb(1100, ok);
        if (ok) model_step(expd);
    endtask

    task automatic wait_busy(input logic level, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (n < 1100 && !ok) begin
            @(negedge clk);
            n++;
            if (busy === level) ok = 1'b1;
        end
        if (!ok) begin
            tests_run++; tests_failed++;
            $display("FAIL busy_timeout: BUSY_o never reached %0b", level);
        end
    endtask

    task automatic test_reset();
        xarst = 1'b0; en_ck = 1'b1; wr = 1'b0; voice = '0; regsel = '0; wdat = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (dat !== 12'h800) begin tests_failed++; $display("FAIL reset_dat: got %h expected 800", dat); end
        tests_run++;
        if (stb !== 1'b0) begin tests_failed++; $display("FAIL reset_stb: got %b expected 0", stb); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        xarst = 1'b1;
        model_reset();
    endtask

    task automatic test_all_disabled();
        bit ok; int expd; int n; int rise; bit prev; bit seen;
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== 12'h800) begin tests_failed++; $display("FAIL idle_dat0: got %h expected 800", dat); end
        end
        n = 0; rise = -1; prev = busy; seen = 1'b0;
        while (n < 1100 && !seen) begin
            @(negedge clk);
            n++;
            if (busy && !prev && rise < 0) rise = n;
            prev = busy;
            if (stb) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 1000) begin tests_failed++; $display("FAIL stb_period: got %0d cycles expected 1000", n); end
        tests_run++;
        if (n - rise != C_VOICES + 1) begin
            tests_failed++; $display("FAIL busy_to_stb: got %0d cycles expected %0d", n - rise, C_VOICES + 1);
        end
        if (seen) begin
            model_step(expd);
            tests_run++;
            if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL idle_dat1: got %h expected %h", dat, expd[11:0]); end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || stb !== 1'b0) begin
            tests_failed++; $display("FAIL after_out: busy=%b stb=%b expected 0 0", busy, stb);
        end
    endtask

    task automatic test_saw();
        bit ok; int expd; logic [11:0] s0;
        s0 = '0;
        write_reg(0, 1, 0); write_reg(0, 2, 255); write_reg(0, 0, 'h100000); write_reg(0, 3, 1);
        for (int s = 0; s <= 16; s++) begin
            next_sample(ok, expd);
            if (ok) begin
                tests_run++;
                if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL saw_model s%0d: got %h expected %h", s, dat, expd[11:0]); end
                if (s == 0) begin
                    s0 = dat;
                    tests_run++;
                    if (dat !== 12'h008) begin tests_failed++; $display("FAIL saw_first: got %h expected 008", dat); end
                end
                if (s == 1) begin
                    tests_run++;
                    if (dat !== 12'h107) begin tests_failed++; $display("FAIL saw_second: got %h expected 107", dat); end
                end
                if (s == 16) begin
                    tests_run++;
                    if (dat !== s0) begin tests_failed++; $display("FAIL saw_period: got %h expected %h", dat, s0); end
                end
            end
        end
        write_reg(0, 3, 0);
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== 12'h800) begin tests_failed++; $display("FAIL saw_off: got %h expected 800", dat); end
        end
    endtask

    task automatic test_square_saturation();
        bit ok; int expd;
        for (int v = 0; v < C_VOICES; v++) begin
            write_reg(v, 1, 1); write_reg(v, 2, 255); write_reg(v, 0, 0); write_reg(v, 3, 1);
        end
        for (int s = 0; s < 2; s++) begin
            next_sample(ok, expd);
            if (ok) begin
                tests_run++;
                if (dat !== 12'hFFF) begin tests_failed++; $display("FAIL square_sat s%0d: got %h expected fff", s, dat); end
                tests_run++;
                if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL square_model s%0d: got %h expected %h", s, dat, expd[11:0]); end
            end
        end
    endtask

    task automatic test_write_in_slot();
        bit ok; int expd;
        logic [11:0] exp_const [3];
        exp_const[0] = 12'h087; exp_const[1] = 12'h107; exp_const[2] = 12'h404;
        write_reg(0, 3, 0); write_reg(1, 3, 0); write_reg(3, 3, 0);
        write_reg(2, 1, 0); write_reg(2, 2, 255); write_reg(2, 0, 'h080000);
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== 12'h008 || dat !== expd[11:0]) begin
                tests_failed++; $display("FAIL slot_a: got %h expected 008 (model %h)", dat, expd[11:0]);
            end
        end
        wait_busy(1'b0, ok);
        wait_busy(1'b1, ok);
        @(negedge clk);
        @(negedge clk);
        wr = 1'b1; voice = 2'd2; regsel = 2'd0; wdat = 24'h300000;
        @(negedge clk);
        wr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            next_sample(ok, expd);
            if (s == 0) model_write(2, 0, 'h300000);
            if (ok) begin
                tests_run++;
                if (dat !== exp_const[s] || dat !== expd[11:0]) begin
                    tests_failed++; $display("FAIL slot_write s%0d: got %h expected %h (model %h)", s, dat, exp_const[s], expd[11:0]);
                end
            end
        end
    endtask

    task automatic test_clock_enable();
        bit ok; int expd; int n; bit frozen_ok; logic [11:0] held;
        write_reg(1, 1, 2); write_reg(1, 2, 200); write_reg(1, 0, 'h0A5A5A); write_reg(1, 3, 1);
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL cken_pre: got %h expected %h", dat, expd[11:0]); end
        end
        wait_busy(1'b0, ok);
        wait_busy(1'b1, ok);
        held = dat;
        @(negedge clk);
        en_ck = 1'b0;
        frozen_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b1 || stb !== 1'b0 || dat !== held) frozen_ok = 1'b0;
        end
        en_ck = 1'b1;
        tests_run++;
        if (!frozen_ok) begin tests_failed++; $display("FAIL cken_freeze: busy=%b stb=%b dat=%h expected 1 0 %h", busy, stb, dat, held); end
        n = 21;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            n++;
            if (stb === 1'b1) ok = 1'b1;
        end
        tests_run++;
        if (!ok || n != C_VOICES + 1 + 20) begin
            tests_failed++; $display("FAIL cken_latency: got %0d cycles expected %0d", n, C_VOICES + 21);
        end
        if (ok) begin
            model_step(expd);
            tests_run++;
            if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL cken_sample: got %h expected %h", dat, expd[11:0]); end
        end
    endtask

    task automatic test_random();
        bit ok; int expd;
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < C_VOICES; v++) begin
                write_reg(v, 0, int'($urandom & 32'h00FF_FFFF));
                write_reg(v, 1, (r == 0 && v == 3) ? 3 : int'($urandom_range(0, 3)));
                write_reg(v, 2, int'($urandom_range(0, 255)));
                write_reg(v, 3, ($urandom_range(0, 3) != 0) ? 1 : 0);
            end
            for (int s = 0; s < 6; s++) begin
                next_sample(ok, expd);
                if (ok) begin
                    tests_run++;
                    if (dat !== expd[11:0]) begin tests_failed++; $display("FAIL random r%0d s%0d: got %h expected %h", r, s, dat, expd[11:0]); end
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        bit ok; int expd;
        wait_busy(1'b0, ok);
        wait_busy(1'b1, ok);
        @(negedge clk);
        xarst = 1'b0;
        #1;
        tests_run++;
        if (dat !== 12'h800 || stb !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_midscan: dat=%h stb=%b busy=%b expected 800 0 0", dat, stb, busy);
        end
        @(negedge clk);
        @(negedge clk);
        xarst = 1'b1;
        model_reset();
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== 12'h800 || dat !== expd[11:0]) begin
                tests_failed++; $display("FAIL post_reset_idle: got %h expected 800", dat);
            end
        end
        write_reg(0, 1, 0); write_reg(0, 2, 255); write_reg(0, 0, 'h100000); write_reg(0, 3, 1);
        next_sample(ok, expd);
        if (ok) begin
            tests_run++;
            if (dat !== 12'h008 || dat !== expd[11:0]) begin
                tests_failed++; $display("FAIL post_reset_saw: got %h expected 008", dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_disabled();
        test_saw();
        test_square_saturation();
        test_write_in_slot();
        test_clock_enable();
        test_random();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
